// File: rtl/fp_i2f32_pkg.sv
// Shared FP32 definitions for the integer-to-float converters.
// Holds the FP32 field layout, exponent bias and rounding-mode encoding.
package fp32Pkg;

    localparam int EMSB = 7;
    localparam int FMSB = 22;
    localparam logic [EMSB:0] BIAS = 8'd127;

    typedef struct packed {
        logic            sign;
        logic [EMSB:0]   exp;
        logic [FMSB:0]   man;
    } FP32;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;

    // Reserved encodings 5-7 fall back to round-to-nearest-even.
    function automatic rm_e decode_rm(input logic [2:0] r);
        case (r)
            3'd1:    return RM_RTZ;
            3'd2:    return RM_RDN;
            3'd3:    return RM_RUP;
            3'd4:    return RM_RMM;
            default: return RM_RNE;
        endcase
    endfunction

endpackage

// File: rtl/fp_i2f32_cntlz32.sv
// Combinational 32-bit leading-zero counter; a zero input reports 32.
module cntlz32 (
    input  logic [31:0] a,
    output logic [5:0]  cnt
);

    // Scan from LSB upward so the highest set bit wins.
    always_comb begin
        cnt = 6'd32;
        for (int unsigned b = 0; b < 32; b++) begin
            if (a[b]) cnt = 6'(31 - b);
        end
    end

endmodule

// File: rtl/fp_i2f32.sv
// Three-stage pipelined 32-bit integer to IEEE-754 single converter with
// valid/ready flow control, a global clock enable and selectable rounding.
module fp_i2f32
    import fp32Pkg::*;
#(
    parameter int PIPE_STAGES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] i,
    input  logic        sgnd,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] o,
    output logic        inexact
);

    generate
        if (PIPE_STAGES != 3) begin : g_bad_depth
            $error("fp_i2f32: PIPE_STAGES must be 3");
        end
    endgenerate

    logic stall, adv;
    assign stall    = out_valid & ~out_ready;
    assign adv      = ce & ~stall;
    assign in_ready = adv;

    // Stage 1: capture, sign, magnitude
    logic        v1, sg1;
    logic [31:0] mag1;
    rm_e         rm1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                sg1  <= sgnd & i[31];
                mag1 <= (sgnd & i[31]) ? (~i + 32'd1) : i;
                rm1  <= decode_rm(rm);
            end
        end
    end

    // Stage 2: leading-zero count and normalize
    logic [5:0]  lzc1;
    logic [31:0] sh1;

    cntlz32 u_lzc (
        .a   (mag1),
        .cnt (lzc1)
    );

    assign sh1 = mag1 << lzc1;

    logic        v2, sg2, zero2;
    logic [30:0] norm2;
    logic [7:0]  exp2;
    rm_e         rm2;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                sg2   <= sg1;
                rm2   <= rm1;
                zero2 <= ~sh1[31];
                norm2 <= sh1[30:0];
                exp2  <= (BIAS + 8'd31) - {2'b00, lzc1};
            end
        end
    end

    // Stage 3: round and pack
    logic        g, st, lsb, inc, ix;
    logic [23:0] sum;
    FP32         res;

    always_comb begin
        g   = norm2[7];
        st  = |norm2[6:0];
        lsb = norm2[8];
        case (rm2)
            RM_RNE:  inc = g & (st | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sg2 & (g | st);
            RM_RUP:  inc = ~sg2 & (g | st);
            RM_RMM:  inc = g;
            default: inc = 1'b0;
        endcase
        // A carry out of the significand leaves sum[22:0] zero already.
        sum      = {1'b0, norm2[30:8]} + {23'd0, inc};
        res.sign = sg2;
        res.exp  = exp2 + {7'd0, sum[23]};
        res.man  = sum[22:0];
        ix       = g | st;
        if (zero2) begin
            res = '0;
            ix  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            o         <= '0;
            inexact   <= 1'b0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                o       <= res;
                inexact <= ix;
            end
        end
    end

endmodule

// File: tb/tb_fp_i2f32.sv
// Directed self-checking bench for fp_i2f32: conversions, rounding modes,
// clock enable, stall back-pressure and reset with operands in flight.
module tb_fp_i2f32;

    logic        clk = 1'b0;
    logic        rst, ce, in_valid, in_ready, sgnd;
    logic        out_valid, out_ready, inexact;
    logic [31:0] i, o;
    logic [2:0]  rm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_i2f32 #(.PIPE_STAGES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i         (i),
        .sgnd      (sgnd),
        .rm        (rm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .inexact   (inexact)
    );

    typedef struct {
        logic [31:0] iv;
        logic        s;
        logic [2:0]  r;
        logic [31:0] e;
        logic        ex;
    } vec_t;

    vec_t vecs [14] = '{
        '{32'h00000001, 1'b1, 3'd0, 32'h3F800000, 1'b0},
        '{32'hFFFFFFFF, 1'b1, 3'd0, 32'hBF800000, 1'b0},
        '{32'hFFFFFFFF, 1'b0, 3'd0, 32'h4F800000, 1'b1},
        '{32'hFFFFFFFF, 1'b0, 3'd1, 32'h4F7FFFFF, 1'b1},
        '{32'h01000001, 1'b0, 3'd0, 32'h4B800000, 1'b1},
        '{32'h01000001, 1'b0, 3'd3, 32'h4B800001, 1'b1},
        '{32'h01000001, 1'b0, 3'd1, 32'h4B800000, 1'b1},
        '{32'h01000001, 1'b0, 3'd4, 32'h4B800001, 1'b1},
        '{32'hFEFFFFFF, 1'b1, 3'd2, 32'hCB800001, 1'b1},
        '{32'hFEFFFFFF, 1'b1, 3'd3, 32'hCB800000, 1'b1},
        '{32'h80000000, 1'b1, 3'd0, 32'hCF000000, 1'b0},
        '{32'h80000000, 1'b0, 3'd0, 32'h4F000000, 1'b0},
        '{32'h00000000, 1'b1, 3'd3, 32'h00000000, 1'b0},
        '{32'h01000003, 1'b0, 3'd7, 32'h4B800002, 1'b1}
    };

    logic [31:0] exp8 [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    // Drives one operand, then scrambles sgnd/rm/i; lat = -1 if no result in 10 cycles.
    task automatic run_one(input logic [31:0] iv, input logic s, input logic [2:0] r,
                           output logic [31:0] ov, output logic ix, output int lat);
        @(negedge clk);
        i = iv; sgnd = s; rm = r; in_valid = 1'b1; out_ready = 1'b1;
        lat = -1; ov = '0; ix = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                in_valid = 1'b0; i = 32'hDEADBEEF; sgnd = ~s; rm = 3'd3;
            end
            if (out_valid) begin
                lat = n; ov = o; ix = inexact;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        i = '0; sgnd = 1'b0; rm = 3'd0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        total++; if (o !== 32'h0) begin bad++; $display("FAIL reset_o: got %h expected 00000000", o); end
        total++; if (inexact !== 1'b0) begin bad++; $display("FAIL reset_inexact: got %b expected 0", inexact); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
    endtask

    task automatic test_convert();
        logic [31:0] ov;
        logic        ix;
        int          lat;
        foreach (vecs[k]) begin
            run_one(vecs[k].iv, vecs[k].s, vecs[k].r, ov, ix, lat);
            total++; if (lat != 3) begin bad++; $display("FAIL conv%0d_latency: got %0d expected 3", k, lat); end
            total++; if (ov !== vecs[k].e) begin bad++; $display("FAIL conv%0d_o i=%h: got %h expected %h", k, vecs[k].iv, ov, vecs[k].e); end
            total++; if (ix !== vecs[k].ex) begin bad++; $display("FAIL conv%0d_inexact: got %b expected %b", k, ix, vecs[k].ex); end
        end
    endtask

    task automatic test_hold();
        logic [31:0] ov;
        logic        ix;
        int          lat;
        run_one(32'h00000007, 1'b0, 3'd0, ov, ix, lat);
        total++; if (ov !== 32'h40E00000) begin bad++; $display("FAIL hold_result: got %h expected 40E00000", ov); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_out_valid: got %b expected 0", out_valid); end
        total++; if (o !== 32'h40E00000) begin bad++; $display("FAIL hold_o: got %h expected 40E00000", o); end
    endtask

    task automatic test_ce();
        int early = 0;
        int lat = -1;
        @(negedge clk);
        i = 32'd5; sgnd = 1'b0; rm = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; ce = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ce_in_ready: got %b expected 0", in_ready); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (out_valid) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL ce_frozen: got %0d early results expected 0", early); end
        ce = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (out_valid) begin lat = n; break; end
        end
        total++; if (lat != 2) begin bad++; $display("FAIL ce_resume_latency: got %0d expected 2", lat); end
        total++; if (o !== 32'h40A00000) begin bad++; $display("FAIL ce_o: got %h expected 40A00000", o); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rc = 0;
        int stalls = 0;
        int extra = 0;
        in_valid = 1'b0; out_ready = 1'b1; sgnd = 1'b0; rm = 3'd0;
        for (int c = 0; c < 60 && rc < 8; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                total++;
                if (o !== exp8[rc]) begin bad++; $display("FAIL b2b_result%0d: got %h expected %h", rc, o, exp8[rc]); end
                rc++;
            end
            if (out_valid && !out_ready) begin
                stalls++;
                total++;
                if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready); end
            end
            out_ready = !(c >= 6 && c < 10);
            in_valid  = (sent < 8);
            i         = 32'(sent + 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (rc != 8) begin bad++; $display("FAIL b2b_count: got %0d expected 8", rc); end
        total++; if (stalls != 4) begin bad++; $display("FAIL b2b_stall_cycles: got %0d expected 4", stalls); end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL b2b_duplicates: got %0d expected 0", extra); end
    endtask

    task automatic test_reset_in_flight();
        int stale = 0;
        logic [31:0] ov;
        logic        ix;
        int          lat;
        out_ready = 1'b1; sgnd = 1'b0; rm = 3'd0;
        @(negedge clk); i = 32'd9;  in_valid = 1'b1;
        @(negedge clk); i = 32'd10;
        @(negedge clk); i = 32'd11; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flight_rst_out_valid: got %b expected 0", out_valid); end
        total++; if (o !== 32'h0) begin bad++; $display("FAIL flight_rst_o: got %h expected 00000000", o); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flight_rst_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL flight_stale: got %0d stale results expected 0", stale); end
        run_one(32'h00000002, 1'b0, 3'd0, ov, ix, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL post_rst_latency: got %0d expected 3", lat); end
        total++; if (ov !== 32'h40000000) begin bad++; $display("FAIL post_rst_o: got %h expected 40000000", ov); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_hold();
        test_ce();
        test_back_to_back();
        test_reset_in_flight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fp_i2f32.md
FP_I2F32 -- requirements
Module: fp_i2f32

Interface
REQ-001 SHALL have parameter PIPE_STAGES, default 3, fixed pipeline depth; other values are illegal.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port ce, input, 1, global clock enable; when low, no state changes.
REQ-005 SHALL have port in_valid, input, 1, operand present.
REQ-006 SHALL have port in_ready, output, 1, operand accepted when in_valid & in_ready.
REQ-007 SHALL have port i, input, 32, integer operand.
REQ-008 SHALL have port sgnd, input, 1, 1 = i is two's-complement signed, 0 = unsigned.
REQ-009 SHALL have port rm, input, 3, rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port o, output, FP32 (32), IEEE-754 single result.
REQ-013 SHALL have port inexact, output, 1, result differs from exact integer value.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 capture, sign, absolute value; S2 leading-zero count and left-normalize; S3 round, exponent, pack.
REQ-015 SHALL present a result on o/out_valid exactly 3 enabled, unstalled cycles after acceptance.
REQ-016 SHALL define stall = out_valid & ~out_ready; stalled or ce low freezes every stage, including valid bits.
REQ-017 SHALL drive in_ready = ce & ~stall, combinationally.
REQ-018 SHALL sustain one accepted operand per cycle when unstalled; no bubbles inserted.
REQ-019 SHALL propagate a valid bit per stage; stage registers for invalid entries are don't-care, but o and inexact hold their value while out_valid is low.
REQ-020 SHALL take magnitude = -i when sgnd & i[31], else i, as 32-bit unsigned; -2^31 yields 0x80000000.
REQ-021 SHALL output +0.0 (0x00000000), inexact 0, for i = 0, in any mode.
REQ-022 SHALL set exponent = 127 + 31 - lzc; significand = normalized bits [30:8]; guard = bit 7; sticky = OR of bits [6:0].
REQ-023 SHALL round per rm: RNE ties to even; RTZ truncate; RDN increment only if negative and inexact; RUP increment only if positive and inexact; RMM increment on guard.
REQ-024 SHALL, on significand carry-out from rounding, increment exponent and zero significand; no overflow is possible (maximum 2^32 = 0x4F800000).
REQ-025 SHALL set inexact = guard | sticky of the rounded value.
REQ-026 SHALL set sign = sgnd & i[31]; unsigned inputs never produce negative results.
REQ-027 SHALL capture rm and sgnd with the operand; later changes SHALL NOT affect in-flight data.
REQ-028 SHALL let out_ready high with out_valid low, and a simultaneous accept and retire, both proceed in the same cycle.

Reset
REQ-029 SHALL, on rst high at a clock edge, clear all stage valid bits, out_valid, o (0x00000000) and inexact, regardless of ce or stall; in-flight operands are discarded.
REQ-030 SHALL drive in_ready per REQ-017 during and after reset; the first acceptance is possible in the cycle after rst deasserts.

Structure
REQ-031 SHALL take the FP32 typedef, EMSB, FMSB and the exponent bias from fp32Pkg; a rounding-mode enum SHALL be added to fp32Pkg.
REQ-032 SHALL instantiate one sub-module, cntlz32, a combinational 32-bit leading-zero counter with a 6-bit result and 32 for zero input.

Verification
REQ-033 SHALL cover: i=1, sgnd=1, rm=RNE -> o=0x3F800000, inexact=0, 3 cycles later.
REQ-034 SHALL cover: i=0xFFFFFFFF with sgnd=1 -> 0xBF800000; with sgnd=0, RNE -> 0x4F800000, inexact=1.
REQ-035 SHALL cover: i=0x01000001, sgnd=0 -> RNE 0x4B800000, inexact=1; RUP 0x4B800001; RTZ 0x4B800000.
REQ-036 SHALL cover: i=0x80000000, sgnd=1 -> 0xCF000000, inexact=0; i=0 -> 0x00000000.
REQ-037 SHALL cover: back-to-back stream of 8 operands with out_ready low for 4 cycles mid-stream -> no loss or duplication, in_ready low while stalled, in-order results.
REQ-038 SHALL cover: rst asserted with 3 operands in flight -> out_valid=0 and o=0 next cycle, with no stale result afterward.
